// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with fill count, almost thresholds, FWFT or registered read,
// read+write-when-full, synchronous flush and sticky overflow/underflow flags.
module sync_fifo_ext #(
  parameter int DataWidth         = 8,
  parameter int Depth             = 16,
  parameter int Fwft              = 0,
  parameter int AlmostFullThresh  = 12,
  parameter int AlmostEmptyThresh = 2,
  localparam int CountWidth       = $clog2(Depth) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_en_i,
  input  logic [DataWidth-1:0]  wr_data_i,
  input  logic                  rd_en_i,
  output logic [DataWidth-1:0]  rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CountWidth-1:0] count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  err_clr_i
);
  localparam int AW = CountWidth - 1;

  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_ext: Depth must be a power of two >= 2");
  end

  logic [DataWidth-1:0]  mem [Depth];
  logic [CountWidth-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0]         wr_idx, rd_idx;
  logic                  rd_ok, wr_ok, ovf_set, udf_set;

  assign wr_idx  = wr_ptr[AW-1:0];
  assign rd_idx  = rd_ptr[AW-1:0];
  // Wrap bit makes full (difference == Depth) distinct from empty (difference == 0).
  assign count_o = wr_ptr - rd_ptr;

  assign full_o         = (count_o == CountWidth'(Depth));
  assign empty_o        = (count_o == '0);
  assign almost_full_o  = (count_o >= CountWidth'(AlmostFullThresh));
  assign almost_empty_o = (count_o <= CountWidth'(AlmostEmptyThresh));

  // Flush masks every request, so it neither moves data nor raises an error.
  assign rd_ok   = rd_en_i & ~empty_o & ~flush_i;
  assign wr_ok   = wr_en_i & (~full_o | (rd_en_i & ~empty_o)) & ~flush_i;
  assign ovf_set = wr_en_i & full_o & ~rd_ok & ~flush_i;
  assign udf_set = rd_en_i & empty_o & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok && !rst_i) mem[wr_idx] <= wr_data_i;
  end

  // A fresh error event in the clear cycle keeps the flag set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (ovf_set)        overflow_o <= 1'b1;
      else if (err_clr_i) overflow_o <= 1'b0;
      if (udf_set)        underflow_o <= 1'b1;
      else if (err_clr_i) underflow_o <= 1'b0;
    end
  end

  if (Fwft != 0) begin : g_fwft
    assign rd_data_o = mem[rd_idx];
  end else begin : g_reg
    logic [DataWidth-1:0] rd_data_q;
    always_ff @(posedge clk_i) begin
      if (rst_i)      rd_data_q <= '0;
      else if (rd_ok) rd_data_q <= mem[rd_idx];
    end
    assign rd_data_o = rd_data_q;
  end
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Randomised + directed bench: registered-read and FWFT instances share stimulus,
// a queue-based reference model feeds scoreboards consumed by a negedge monitor.
module tb_sync_fifo_ext;
  localparam int D = 16;
  localparam int AFT = 12;
  localparam int AET = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = '0;

  logic [7:0] rd_data0, rd_data1;
  logic       full0, empty0, af0, ae0, ov0, uf0;
  logic       full1, empty1, af1, ae1, ov1, uf1;
  logic [4:0] cnt0, cnt1;

  sync_fifo_ext #(.DataWidth(8), .Depth(D), .Fwft(0), .AlmostFullThresh(AFT),
                  .AlmostEmptyThresh(AET)) u_reg (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd_data0), .full_o(full0), .empty_o(empty0),
    .almost_full_o(af0), .almost_empty_o(ae0), .count_o(cnt0), .overflow_o(ov0),
    .underflow_o(uf0), .err_clr_i(err_clr));

  sync_fifo_ext #(.DataWidth(8), .Depth(D), .Fwft(1), .AlmostFullThresh(AFT),
                  .AlmostEmptyThresh(AET)) u_fw (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .rd_en_i(rd_en), .rd_data_o(rd_data1), .full_o(full1), .empty_o(empty1),
    .almost_full_o(af1), .almost_empty_o(ae1), .count_o(cnt1), .overflow_o(ov1),
    .underflow_o(uf1), .err_clr_i(err_clr));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model
  int   q[$];
  bit   m_ov, m_uf;
  int   m_last;
  int   sb_reg[$];
  int   sb_fw[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumers: registered data valid after the accepting edge,
  // FWFT head visible while the model holds data.
  always @(negedge clk) begin
    if (sb_reg.size() > 0) chk("reg_rd_data", int'(rd_data0), sb_reg.pop_front());
    if (sb_fw.size() > 0)  chk("fwft_rd_data", int'(rd_data1), sb_fw.pop_front());
  end

  task automatic check_status();
    int n = q.size();
    chk("count", int'(cnt0), n);
    chk("count_fw", int'(cnt1), n);
    chk("full", int'(full0), int'(n == D));
    chk("empty", int'(empty0), int'(n == 0));
    chk("almost_full", int'(af0), int'(n >= AFT));
    chk("almost_empty", int'(ae0), int'(n <= AET));
    chk("empty_fw", int'(empty1), int'(n == 0));
    chk("full_fw", int'(full1), int'(n == D));
    chk("overflow", int'(ov0), int'(m_ov));
    chk("underflow", int'(uf0), int'(m_uf));
    chk("overflow_fw", int'(ov1), int'(m_ov));
    chk("underflow_fw", int'(uf1), int'(m_uf));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_ov = 0; m_uf = 0; m_last = 0;
    check_status();
    chk("reset_rd_data", int'(rd_data0), 0);
  endtask

  task automatic step(input bit wr, input int d, input bit rd, input bit fl, input bit clr);
    bit rdok, wrok, ovs, ufs;
    wr_en = wr; wr_data = 8'(d); rd_en = rd; flush = fl; err_clr = clr;
    rdok = 0; wrok = 0; ovs = 0; ufs = 0;
    if (!fl) begin
      rdok = rd && q.size() > 0;
      wrok = wr && (q.size() < D || rdok);
      ovs  = wr && q.size() == D && !rdok;
      ufs  = rd && q.size() == 0;
    end
    @(posedge clk); #1;
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
    if (fl) q.delete();
    if (rdok) begin
      m_last = q.pop_front();
      sb_reg.push_back(m_last);
    end
    if (wrok) q.push_back(d & 8'hFF);
    m_ov = ovs ? 1'b1 : (clr ? 1'b0 : m_ov);
    m_uf = ufs ? 1'b1 : (clr ? 1'b0 : m_uf);
    if (q.size() > 0) sb_fw.push_back(q[0]);
    if (!rdok) chk("rd_data_hold", int'(rd_data0), m_last);
    check_status();
  endtask

  initial begin
    do_reset();
    // ordered fill and drain
    for (int i = 1; i <= 16; i++) step(1, i, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
    // simultaneous read+write while full
    for (int i = 0; i < 16; i++) step(1, $urandom_range(0, 255), 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    // write while full drops the word, then clear
    step(1, 8'h77, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
    // underflow, then read+write on empty
    step(0, 0, 1, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    // FWFT single word
    step(1, 8'h3C, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    // flush overrides write, sticky underflow kept
    for (int i = 0; i < 5; i++) step(1, 8'h90 + i, 0, 0, 0);
    step(1, 8'hEE, 1, 1, 0);
    step(0, 0, 0, 0, 1);
    // pointer wrap
    for (int i = 0; i < 40; i++) begin
      step(1, (i * 7 + 3) & 8'hFF, 0, 0, 0);
      step(0, 0, 1, 0, 0);
    end
    // random traffic with occasional flush, clear and mid-run reset
    for (int i = 0; i < 2500; i++) begin
      int phase = (i / 300) % 3;
      bit wr = ($urandom_range(0, 99) < (phase == 0 ? 70 : (phase == 1 ? 30 : 50)));
      bit rd = ($urandom_range(0, 99) < (phase == 0 ? 30 : (phase == 1 ? 70 : 50)));
      bit fl = ($urandom_range(0, 59) == 0);
      bit cl = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(wr, $urandom_range(0, 255), rd, fl, cl);
    end
    @(negedge clk); #1;
    chk("sb_reg_drained", sb_reg.size(), 0);
    chk("sb_fw_drained", sb_fw.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
